prog_loader: RTL and testbench

Program loader that sits directly upstream of `risc_processor`. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction ROM. After a checksum check passes, it pulses `start` to launch execution. It replaces the testbench's direct `rom_mem` pokes and its hand-timed `start` pulse with a synthesizable boot path.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_word_packer.sv | 42 ++++
 rtl/prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader boot path.
package prog_loader_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned BYTES_PER_WORD   = 4;
    localparam int unsigned DEF_START_CYCLES = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_START = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } pl_state_e;

    // A count byte is usable when it is non-zero and fits the ROM.
    function automatic logic count_valid(input logic [BYTE_W-1:0] n, input int unsigned addr_w);
        return (n != '0) && (32'(n) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and ROM write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_we, rom_addr, rom_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_we, rom_addr, rom_wdata
    );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Big-endian byte-to-word packer: three held bytes plus the byte being accepted.
module pl_word_packer
    import prog_loader_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready
);

    localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned HOLD_W = BYTE_W * (BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] sreg_q, sreg_d;

    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        if (byte_valid) begin
            cnt_d  = cnt_q + CNT_W'(1);
            sreg_d = {sreg_q[HOLD_W-BYTE_W-1:0], byte_data};
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sreg_q <= sreg_d;
        end
    end

    // The last byte completes the word in the same cycle it is accepted.
    assign word_ready = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_c     = {sreg_q, byte_data};

endmodule

// File: rtl/prog_loader.sv
// Boot loader: byte stream -> instruction ROM writes -> checksum -> start pulse.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES
) (
    input  logic         clk1,
    input  logic         rst_n,
    prog_loader_if.slave bus,
    output logic         start,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned TIMER_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    pl_state_e state_q, state_d;

    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0]  n_q, n_d;
    logic [BYTE_W-1:0]  xor_q, xor_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic              in_ready_q, in_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              pack_valid_c;
    logic              word_ready;
    logic [WORD_W-1:0] word_c;

    assign accept_c     = bus.in_valid && in_ready_q;
    assign pack_valid_c = accept_c && (state_q == ST_LOAD);

    pl_word_packer u_packer (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .byte_valid (pack_valid_c),
        .byte_data  (bus.in_data),
        .word_c     (word_c),
        .word_ready (word_ready)
    );

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = count_valid(bus.in_data, ADDR_W) ? ST_LOAD : ST_ERR;
                end
            end
            ST_LOAD: begin
                if (word_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ((32'(idx_q) + 32'd1) == 32'(n_q)) ? ST_CHECK : ST_LOAD;
            end
            ST_CHECK: begin
                if (accept_c) begin
                    state_d = (bus.in_data == xor_q) ? ST_START : ST_ERR;
                end
            end
            ST_START: begin
                if (32'(timer_q) == (START_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        in_ready_d  = 1'b0;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        start_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_d)
            ST_IDLE: in_ready_d = 1'b1;
            ST_LOAD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_WRITE: begin
                busy_d      = 1'b1;
                rom_we_d    = 1'b1;
                rom_addr_d  = idx_q;
                rom_wdata_d = word_c;
            end
            ST_CHECK: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_START: begin
                busy_d  = 1'b1;
                start_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            ST_ERR:  err_d  = 1'b1;
            default: in_ready_d = 1'b0;
        endcase
    end

    // Word index, count, running XOR (checksum byte excluded) and start timer
    always_comb begin
        idx_d   = idx_q;
        n_d     = n_q;
        xor_d   = xor_q;
        timer_d = '0;
        if (accept_c && (state_q != ST_CHECK)) begin
            xor_d = xor_q ^ bus.in_data;
        end
        if (accept_c && (state_q == ST_IDLE)) begin
            n_d = bus.in_data;
        end
        if (state_q == ST_WRITE) begin
            idx_d = idx_q + ADDR_W'(1);
        end
        if (state_q == ST_START) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            n_q         <= '0;
            xor_q       <= '0;
            timer_q     <= '0;
            in_ready_q  <= 1'b1;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            n_q         <= n_d;
            xor_q       <= xor_d;
            timer_q     <= timer_d;
            in_ready_q  <= in_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rom_we    = rom_we_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_wdata = rom_wdata_q;
    assign start         = start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stream-level vector table plus reset/backpressure sequences.
module tb_prog_loader;

    logic clk1;
    logic rst_n;
    logic start, busy, done, err;

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.ADDR_W(8), .START_CYCLES(10)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    logic [39:0] wq[$];
    int          start_cnt = 0;
    logic        prev_we = 1'b0;
    logic [31:0] prog [0:16];

    typedef struct {
        int         n;
        int         base;
        logic [7:0] cks_add;
        logic       exp_done;
        logic       exp_err;
    } row_t;

    row_t rows [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture ROM writes and start-high cycles between clock edges
    always @(negedge clk1) begin
        if (bus.rom_we) begin
            wq.push_back({bus.rom_addr, bus.rom_wdata});
            check("we_gap", 32'(prev_we), 32'd0);
        end
        prev_we = bus.rom_we;
        if (start) start_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk1);
        wq.delete();
        start_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk1);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk1);
    endtask

    function automatic logic [7:0] word_byte(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    task automatic send_stream(input int n, input int base, input logic [7:0] cks_add);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'(n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = word_byte(prog[base+i], k);
                x = x ^ b;
                send_byte(b);
            end
        end
        send_byte(x + cks_add);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || err) && n < 60) begin
            @(negedge clk1);
            n++;
        end
        check("finish", 32'(done | err), 32'd1);
    endtask

    task automatic check_writes(input int n, input int base);
        logic [39:0] e;
        check("n_writes", 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            e = wq[i];
            check("wr_addr", 32'(e[39:32]), 32'(i));
            check("wr_data", e[31:0], prog[base+i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rom_we", 32'(bus.rom_we), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_rom_wdata", bus.rom_wdata, 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0] bytes [0:9];
        logic [7:0] x;
        int bub;

        prog[0]  = 32'h30020000; prog[1]  = 32'h32020006; prog[2]  = 32'h0F000000;
        prog[3]  = 32'h31040001; prog[4]  = 32'h22430000; prog[5]  = 32'h10C00002;
        prog[6]  = 32'h3A0A0003; prog[7]  = 32'h20650000; prog[8]  = 32'h18000004;
        prog[9]  = 32'h2C210005; prog[10] = 32'h34060007; prog[11] = 32'h0A400008;
        prog[12] = 32'h1E280009; prog[13] = 32'h36E2000A; prog[14] = 32'h28A1000B;
        prog[15] = 32'h3C00000C; prog[16] = 32'h12000000;

        rows[0] = '{n: 17, base: 0,  cks_add: 8'h00, exp_done: 1'b1, exp_err: 1'b0};
        rows[1] = '{n: 1,  base: 2,  cks_add: 8'h01, exp_done: 1'b0, exp_err: 1'b1};
        rows[2] = '{n: 1,  base: 16, cks_add: 8'h00, exp_done: 1'b1, exp_err: 1'b0};
        rows[3] = '{n: 3,  base: 4,  cks_add: 8'h80, exp_done: 1'b0, exp_err: 1'b1};
        rows[4] = '{n: 2,  base: 0,  cks_add: 8'h00, exp_done: 1'b1, exp_err: 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        #12;
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk1);

        // Stream-level vector table
        for (int r = 0; r < 5; r++) begin
            do_reset();
            send_stream(rows[r].n, rows[r].base, rows[r].cks_add);
            wait_end();
            @(negedge clk1);
            check("done", 32'(done), 32'(rows[r].exp_done));
            check("err", 32'(err), 32'(rows[r].exp_err));
            check("busy_end", 32'(busy), 32'd0);
            check("in_ready_end", 32'(bus.in_ready), 32'd0);
            check("start_cycles", 32'(start_cnt), rows[r].exp_done ? 32'd10 : 32'd0);
            check_writes(rows[r].n, rows[r].base);
        end

        // Bubbles and backpressure: byte after the 4th is held through WRITE
        do_reset();
        x = 8'h02;
        bytes[0] = 8'h02;
        for (int i = 0; i < 8; i++) begin
            bytes[i+1] = word_byte(prog[i/4], i % 4);
            x = x ^ bytes[i+1];
        end
        bytes[9] = x;
        for (int i = 0; i < 10; i++) begin
            bub = (i == 5) ? 0 : int'($urandom_range(0, 2));
            if (bub > 0) begin
                bus.in_valid = 1'b0;
                repeat (bub) @(negedge clk1);
            end
            send_byte(bytes[i]);
            if (i == 4) begin
                check("wr_latency_we", 32'(bus.rom_we), 32'd1);
                check("wr_latency_ready", 32'(bus.in_ready), 32'd0);
                check("wr_latency_data", bus.rom_wdata, 32'h30020000);
            end
        end
        bus.in_valid = 1'b0;
        wait_end();
        check("bub_done", 32'(done), 32'd1);
        check_writes(2, 0);
        check("hold_addr", 32'(bus.rom_addr), 32'd1);
        check("hold_data", bus.rom_wdata, 32'h32020006);

        // Zero count: err in the very next cycle
        do_reset();
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        check("zero_err", 32'(err), 32'd1);
        check("zero_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk1);
        check("zero_writes", 32'(wq.size()), 32'd0);
        check("zero_start", 32'(start_cnt), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);

        // Reset mid-load after 6 bytes of N=3
        do_reset();
        send_byte(8'h03);
        for (int i = 0; i < 5; i++) send_byte(word_byte(prog[i/4], i % 4));
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        check("midload_writes", 32'(wq.size()), 32'd1);
        repeat (2) @(negedge clk1);
        wq.delete();
        start_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk1);
        send_stream(1, 1, 8'h00);
        wait_end();
        @(negedge clk1);
        check("reload_done", 32'(done), 32'd1);
        check("reload_start", 32'(start_cnt), 32'd10);
        check_writes(1, 1);

        // Reset during START
        do_reset();
        send_stream(1, 0, 8'h00);
        check("start_high", 32'(start), 32'd1);
        repeat (3) @(negedge clk1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_start_drop", 32'(start), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk1);
        check("rst_start_done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
